// File: rtl/slice_serial_alu_if.sv
// slice_serial_alu_if: start/done handshake and operand/result bus of the serial slice ALU
interface slice_serial_alu_if #(parameter int WIDTH = 16);
  logic start_i, chain_i, m_i, c_n_i;
  logic [WIDTH-1:0] a_i, b_i;
  logic [3:0] s_i;
  logic ready_o, done_o, c_n_out_o, a_eq_b_o, g_o, p_o;
  logic [WIDTH-1:0] f_o;
  modport master (
    output start_i, chain_i, a_i, b_i, s_i, m_i, c_n_i,
    input  ready_o, done_o, f_o, c_n_out_o, a_eq_b_o, g_o, p_o
  );
  modport slave (
    input  start_i, chain_i, a_i, b_i, s_i, m_i, c_n_i,
    output ready_o, done_o, f_o, c_n_out_o, a_eq_b_o, g_o, p_o
  );
endinterface

// File: rtl/slice_serial_alu.sv
// slice_serial_alu: WIDTH-bit 74181-style ALU evaluated one 4-bit slice per clock
module slice_serial_alu #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  slice_serial_alu_if.slave bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int KW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q;
  logic [KW-1:0] k_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, f_q, res_d;
  logic [3:0] s_q, x, y, sl;
  logic [4:0] sum;
  logic m_q, c_q, carry_q, gacc_q, pacc_q;
  logic done_q, c_n_out_q, a_eq_b_q, g_q, p_q;
  logic g_k, g_d, p_d, last;
  always_comb begin
    x = a_q[3:0] | (b_q[3:0] & {4{s_q[0]}}) | (~b_q[3:0] & {4{s_q[1]}});
    y = (a_q[3:0] & ~b_q[3:0] & {4{s_q[2]}}) | (a_q[3:0] & b_q[3:0] & {4{s_q[3]}});
    sum = {1'b0, x} + {1'b0, y} + {4'b0, c_q};
    // y implies x bitwise, so x alone serves as the propagate term
    g_k = y[3] | (x[3] & (y[2] | (x[2] & (y[1] | (x[1] & y[0])))));
    g_d = g_k | (&x & gacc_q);
    p_d = pacc_q & (&x);
    sl = m_q ? ~(x ^ y) : sum[3:0];
    res_d = (res_q >> 4) | (WIDTH'(sl) << (WIDTH - 4));
    last = k_q == KW'(NSLICE - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      s_q <= '0;
      m_q <= 1'b0;
      c_q <= 1'b0;
      gacc_q <= 1'b0;
      pacc_q <= 1'b0;
      carry_q <= 1'b0;
      f_q <= '0;
      done_q <= 1'b0;
      c_n_out_q <= 1'b1;
      a_eq_b_q <= 1'b0;
      g_q <= 1'b0;
      p_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start_i) begin
          state_q <= RUN;
          k_q <= '0;
          a_q <= bus.a_i;
          b_q <= bus.b_i;
          s_q <= bus.s_i;
          m_q <= bus.m_i;
          c_q <= bus.chain_i ? carry_q : ~bus.c_n_i;
          gacc_q <= 1'b0;
          pacc_q <= 1'b1;
        end
        RUN: begin
          a_q <= a_q >> 4;
          b_q <= b_q >> 4;
          res_q <= res_d;
          c_q <= sum[4];
          gacc_q <= g_d;
          pacc_q <= p_d;
          k_q <= k_q + KW'(1);
          if (last) begin
            state_q <= IDLE;
            done_q <= 1'b1;
            f_q <= res_d;
            c_n_out_q <= m_q | ~sum[4];
            a_eq_b_q <= &res_d;
            g_q <= ~m_q & g_d;
            p_q <= ~m_q & p_d;
            carry_q <= ~m_q & sum[4];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.ready_o = state_q == IDLE;
  assign bus.done_o = done_q;
  assign bus.f_o = f_q;
  assign bus.c_n_out_o = c_n_out_q;
  assign bus.a_eq_b_o = a_eq_b_q;
  assign bus.g_o = g_q;
  assign bus.p_o = p_q;
endmodule

// File: tb/tb_slice_serial_alu.sv
// tb_slice_serial_alu: directed vector table plus handshake/reset sequences for 16- and 32-bit instances
module tb_slice_serial_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  slice_serial_alu_if #(.WIDTH(16)) b16 ();
  slice_serial_alu_if #(.WIDTH(32)) b32 ();
  slice_serial_alu #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
  slice_serial_alu #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));

  typedef struct {
    logic [15:0] a, b;
    logic [3:0] s;
    logic m, cn, ch;
    logic [15:0] f;
    logic co, eq, g, p;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic wait_done16(input int acc, input int exp_lat, input string n);
    while (!b16.done_o && cyc - acc < 30) begin
      @(posedge clk);
      #1;
    end
    chk({n, " latency"}, cyc - acc, exp_lat);
  endtask

  task automatic run16(input vec_t v, input string n);
    int acc;
    @(negedge clk);
    chk({n, " ready"}, b16.ready_o, 1'b1);
    b16.a_i = v.a;
    b16.b_i = v.b;
    b16.s_i = v.s;
    b16.m_i = v.m;
    b16.c_n_i = v.cn;
    b16.chain_i = v.ch;
    b16.start_i = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    b16.start_i = 1'b0;
    wait_done16(acc, 4, n);
    chk({n, " f"}, b16.f_o, v.f);
    chk({n, " c_n_out"}, b16.c_n_out_o, v.co);
    chk({n, " a_eq_b"}, b16.a_eq_b_o, v.eq);
    chk({n, " g"}, b16.g_o, v.g);
    chk({n, " p"}, b16.p_o, v.p);
    @(posedge clk);
    #1;
    chk({n, " pulse"}, b16.done_o, 1'b0);
  endtask

  initial begin
    int acc;
    logic seen;
    vt[0]  = '{16'h1234, 16'h0FF0, 4'b1001, 1'b0, 1'b1, 1'b0, 16'h2224, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{16'hBEEF, 16'hBEEF, 4'b0110, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{16'hBEEF, 16'hBEEF, 4'b0110, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[4]  = '{16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b0, 16'h0FF0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{16'h7FFF, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{16'h0000, 16'h1234, 4'b0000, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[11] = '{16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    {b16.start_i, b16.chain_i, b16.m_i, b16.c_n_i} = 4'b0001;
    b16.a_i = '0;
    b16.b_i = '0;
    b16.s_i = '0;
    {b32.start_i, b32.chain_i, b32.m_i, b32.c_n_i} = 4'b0001;
    b32.a_i = '0;
    b32.b_i = '0;
    b32.s_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst ready", b16.ready_o, 1'b1);
    chk("rst done", b16.done_o, 1'b0);
    chk("rst f", b16.f_o, 16'h0);
    chk("rst c_n_out", b16.c_n_out_o, 1'b1);
    chk("rst a_eq_b", b16.a_eq_b_o, 1'b0);
    chk("rst g", b16.g_o, 1'b0);
    chk("rst p", b16.p_o, 1'b0);
    chk("rst32 ready", b32.ready_o, 1'b1);
    chk("rst32 f", b32.f_o, 32'h0);

    for (int i = 0; i < 11; i++) run16(vt[i], $sformatf("v%0d", i));

    // operand, select and start changes during RUN must not disturb the op in flight
    @(negedge clk);
    b16.a_i = 16'hF0F0;
    b16.b_i = 16'hFF00;
    b16.s_i = 4'b0110;
    b16.m_i = 1'b1;
    b16.chain_i = 1'b0;
    b16.start_i = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("tog ready %0d", i), b16.ready_o, 1'b0);
      b16.a_i = 16'($urandom);
      b16.b_i = 16'($urandom);
      b16.s_i = 4'($urandom);
      b16.m_i = 1'($urandom);
      b16.start_i = (i != 1);
    end
    @(negedge clk);
    b16.start_i = 1'b0;
    wait_done16(acc, 4, "tog");
    chk("tog f", b16.f_o, 16'h0FF0);
    chk("tog c_n_out", b16.c_n_out_o, 1'b1);
    chk("tog g", b16.g_o, 1'b0);
    chk("tog p", b16.p_o, 1'b0);
    @(posedge clk);
    #1;

    // start held high: one op every 5 cycles
    @(negedge clk);
    b16.a_i = 16'h0001;
    b16.b_i = 16'h0001;
    b16.s_i = 4'b1001;
    b16.m_i = 1'b0;
    b16.c_n_i = 1'b1;
    b16.chain_i = 1'b0;
    b16.start_i = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("b2b ready %0d", i), b16.ready_o, (i % 5 == 4));
      chk($sformatf("b2b done %0d", i), b16.done_o, (i % 5 == 4));
      if (i % 5 == 4) chk($sformatf("b2b f %0d", i), b16.f_o, 16'h0002);
      if (i == 14) b16.start_i = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("b2b idle", b16.ready_o, 1'b1);

    // abort mid-RUN after loading carry_reg=1
    run16(vt[3], "pre_rst");
    @(negedge clk);
    b16.a_i = 16'h1234;
    b16.b_i = 16'h0001;
    b16.s_i = 4'b1001;
    b16.m_i = 1'b0;
    b16.c_n_i = 1'b1;
    b16.chain_i = 1'b0;
    b16.start_i = 1'b1;
    @(posedge clk);
    #1;
    b16.start_i = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort ready", b16.ready_o, 1'b1);
    chk("abort done", b16.done_o, 1'b0);
    chk("abort f", b16.f_o, 16'h0);
    chk("abort c_n_out", b16.c_n_out_o, 1'b1);
    chk("abort g", b16.g_o, 1'b0);
    chk("abort p", b16.p_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (b16.done_o) seen = 1'b1;
    end
    chk("abort no done", seen, 1'b0);
    run16(vt[11], "post_rst_chain");

    // 32-bit instance: full-width ripple
    @(negedge clk);
    b32.a_i = 32'hFFFFFFFF;
    b32.b_i = 32'h00000001;
    b32.s_i = 4'b1001;
    b32.m_i = 1'b0;
    b32.c_n_i = 1'b1;
    b32.chain_i = 1'b0;
    b32.start_i = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    b32.start_i = 1'b0;
    while (!b32.done_o && cyc - acc < 30) begin
      @(posedge clk);
      #1;
    end
    chk("w32 latency", cyc - acc, 8);
    chk("w32 f", b32.f_o, 32'h0);
    chk("w32 c_n_out", b32.c_n_out_o, 1'b0);
    chk("w32 g", b32.g_o, 1'b1);
    chk("w32 p", b32.p_o, 1'b1);
    @(posedge clk);
    #1;
    chk("w32 pulse", b32.done_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
